// File: rtl/pwm_pkg.sv
// Shared constants and types for the multichannel PWM block.
// The count-direction enum is only used when PWM_CENTER_ALIGN_EN is defined.
package pwm_pkg;

  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 4;

  // Period shadow value out of reset; sliced down to CNT_W where used.
  localparam logic [31:0] RESET_PERIOD = '1;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_multichannel_if.sv
// Duty-cycle write bus from the register file into the PWM block.
// duty_wr is a single-cycle write strobe with no ready/back-pressure: every
// cycle with duty_wr=1 is one write of duty_data to channel duty_ch, and it is
// always accepted. Channel indices with no matching channel are dropped.
interface pwm_multichannel_if #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             duty_wr;
  logic [CH_W-1:0]  duty_ch;
  logic [CNT_W-1:0] duty_data;

  modport master (output duty_wr, duty_ch, duty_data);
  modport slave  (input  duty_wr, duty_ch, duty_data);
endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: clock prescaler, period counter and period shadow.
// o_load is high in the cycle whose clock edge wraps the counter (shadow-load
// edge); o_period_tick is the registered pulse seen in the cycle after it.
// Build option PWM_CENTER_ALIGN_EN selects an up/down (triangle) counter.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   i_period,
  input  logic [PRESC_W-1:0] i_presc,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_load,
  output logic               o_period_tick
);

  logic [PRESC_W-1:0] r_presc_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_period_sh;
  logic               r_period_tick;
  logic               w_tick;
  logic               w_wrap;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // The prescaler compare is live, so a new presc applies immediately.
  assign w_tick = (r_presc_cnt == i_presc);

`ifdef PWM_CENTER_ALIGN_EN
  cnt_dir_e r_dir;
  cnt_dir_e w_dir_nxt;

  // Triangle count: 0..P up, P-1..1 down, wrap to 0; each endpoint lasts one tick.
  always_comb begin
    w_wrap    = 1'b0;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (r_dir == UP) begin
      if (r_cnt == r_period_sh) begin
        if (r_period_sh <= CNT_W'(1)) begin
          w_wrap    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_dir_nxt = DOWN;
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end else if (r_cnt <= CNT_W'(1)) begin
      w_wrap    = 1'b1;
      w_cnt_nxt = '0;
      w_dir_nxt = UP;
    end else begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // Direction state register, advanced on prescaler ticks only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_dir <= UP;
    else if (w_tick) r_dir <= w_dir_nxt;
  end
`else
  // Sawtooth count: wrap to 0 after reaching the shadowed terminal count.
  always_comb begin
    w_wrap    = (r_cnt == r_period_sh);
    w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
  end
`endif

  assign o_load = w_tick & w_wrap;

  // Prescaler: return to 0 on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc_cnt <= '0;
    else if (w_tick) r_presc_cnt <= '0;
    else             r_presc_cnt <= r_presc_cnt + 1'b1;
  end

  // Counter, period shadow and the registered wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_period_sh   <= RESET_PERIOD[CNT_W-1:0];
      r_period_tick <= 1'b0;
    end else begin
      r_period_tick <= o_load;
      if (w_tick) r_cnt <= w_cnt_nxt;
      if (o_load) r_period_sh <= i_period;
    end
  end

  assign o_cnt         = r_cnt;
  assign o_period_tick = r_period_tick;

endmodule

// File: rtl/pwm_multichannel.sv
// NUM_CH PWM outputs sharing one prescaled timebase. Each channel owns a
// staging duty register (written from the duty bus) and a shadow duty register
// loaded at the period wrap, so outputs never see a partial-period duty change.
// Build option PWM_CENTER_ALIGN_EN (in pwm_timebase) gives centre-aligned pulses.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    en_out,
  input  logic [NUM_CH-1:0]    en_pwm,
  pwm_multichannel_if.slave    duty_bus,
  input  logic [CNT_W-1:0]     period,
  input  logic [PRESC_W-1:0]   presc,
  output logic [NUM_CH-1:0]    out,
  output logic                 period_tick
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0] w_cnt;
  logic             w_load;

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_period      (period),
    .i_presc       (presc),
    .o_cnt         (w_cnt),
    .o_load        (w_load),
    .o_period_tick (period_tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_stage;
    logic [CNT_W-1:0] r_shadow;
    logic             r_out;
    logic             w_sel;

    // Out-of-range channel indices match no slice and are dropped.
    assign w_sel = duty_bus.duty_wr && (duty_bus.duty_ch == CH_W'(i));

    // Staging duty: written any cycle; a write on the load edge misses that load.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_stage <= '0;
      else if (w_sel) r_stage <= duty_bus.duty_data;
    end

    // Shadow duty: takes the staging value only at the period wrap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_shadow <= '0;
      else if (w_load) r_shadow <= r_stage;
    end

    // Registered output; enables are live with one clock of latency.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out <= 1'b0;
      else        r_out <= en_out[i] & (en_pwm[i] ? (w_cnt < r_shadow) : 1'b1);
    end

    assign out[i] = r_out;
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: directed period/duty measurements, a table of
// enable vectors, a mid-run reset, then random traffic checked every cycle
// against a tick-position reference model.
module tb_pwm_multichannel;
  localparam int NCH = 16;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int FIRST_WRAP = 510;
`else
  localparam int FIRST_WRAP = 256;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en_out = '0;
  logic [NCH-1:0] en_pwm = '0;
  logic [7:0]     period = 8'd255;
  logic [3:0]     presc = 4'd0;
  logic [NCH-1:0] out;
  logic           period_tick;

  pwm_multichannel_if #(.NUM_CH(NCH), .CNT_W(8)) dbus ();

  pwm_multichannel #(.NUM_CH(NCH), .CNT_W(8), .PRESC_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_out      (en_out),
    .en_pwm      (en_pwm),
    .duty_bus    (dbus),
    .period      (period),
    .presc       (presc),
    .out         (out),
    .period_tick (period_tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Period position is counted in ticks from the last wrap; the counter value
  // is derived from it arithmetically.
  logic [NCH:0] exp_q[$];
  logic [3:0]   m_since;
  int           m_pos;
  int           m_per;
  int           m_stage[NCH];
  int           m_sh[NCH];

  function automatic int per_len(input int p);
`ifdef PWM_CENTER_ALIGN_EN
    return (p == 0) ? 1 : 2 * p;
`else
    return p + 1;
`endif
  endfunction

  function automatic int cnt_at(input int pos, input int p);
`ifdef PWM_CENTER_ALIGN_EN
    return (pos <= p) ? pos : 2 * p - pos;
`else
    return pos + 0 * p;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [NCH-1:0] e_out;
    logic           e_tick;
    int             c;
    if (!rst_n) begin
      m_since = '0;
      m_pos   = 0;
      m_per   = 255;
      for (int i = 0; i < NCH; i++) begin m_stage[i] = 0; m_sh[i] = 0; end
      exp_q.delete();
    end else begin
      c = cnt_at(m_pos, m_per);
      for (int i = 0; i < NCH; i++)
        e_out[i] = en_out[i] & (en_pwm[i] ? (c < m_sh[i]) : 1'b1);
      e_tick = 1'b0;
      if (m_since == presc) begin
        m_since = '0;
        if (m_pos == per_len(m_per) - 1) begin
          m_pos  = 0;
          e_tick = 1'b1;
          for (int i = 0; i < NCH; i++) m_sh[i] = m_stage[i];
          m_per  = int'(period);
        end else begin
          m_pos = m_pos + 1;
        end
      end else begin
        m_since = m_since + 4'd1;
      end
      if (dbus.duty_wr && int'(dbus.duty_ch) < NCH) m_stage[dbus.duty_ch] = int'(dbus.duty_data);
      exp_q.push_back({e_tick, e_out});
    end
  end

  // Scoreboard: compare every cycle, away from the active edge.
  always @(negedge clk) begin : scoreboard
    logic [NCH:0] e;
    if (!rst_n) begin
      check("rst_out", 32'(out), 32'd0);
      check("rst_tick", 32'(period_tick), 32'd0);
    end else if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: got no expected entry required one (t=%0t)", $time);
    end else begin
      e = exp_q.pop_front();
      check("model_out", 32'(out), 32'(e[NCH-1:0]));
      check("model_tick", 32'(period_tick), 32'(e[NCH]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write_duty(input int ch, input logic [7:0] data);
    dbus.duty_wr   = 1'b1;
    dbus.duty_ch   = 4'(ch);
    dbus.duty_data = data;
    step(1);
    dbus.duty_wr   = 1'b0;
  endtask

  // Steps until period_tick is seen, counting clocks and high samples per
  // channel; optionally writes a duty value at clock index wr_at.
  task automatic measure(input int wr_at, input int wr_ch, input logic [7:0] wr_data,
                         input int budget, output int clks, output int hi[NCH]);
    bit seen;
    seen = 1'b0;
    clks = 0;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    while (!seen && clks < budget) begin
      if (clks == wr_at) begin
        dbus.duty_wr   = 1'b1;
        dbus.duty_ch   = 4'(wr_ch);
        dbus.duty_data = wr_data;
      end
      step(1);
      dbus.duty_wr = 1'b0;
      clks++;
      for (int i = 0; i < NCH; i++) if (out[i]) hi[i]++;
      seen = period_tick;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL measure_timeout: got no period_tick within %0d clks", budget);
    end
  endtask

  task automatic chk_win(input string name, input int clks, input int exp_clks,
                         input int hi0, input int exp_hi0);
    check({name, "_clks"}, 32'(clks), 32'(exp_clks));
    check({name, "_hi0"}, 32'(hi0), 32'(exp_hi0));
  endtask

  // ---------------- enable vector table ----------------
  typedef struct {
    int   ch;
    logic eo;
    logic ep;
    logic exp;
  } en_vec_t;
  en_vec_t vecs[9];

  // ---------------- main sequence ----------------
  initial begin : main
    int clks;
    int hi[NCH];

    vecs[0] = '{3, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{3, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{2, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1, 1'b1, 1'b1, 1'b0};

    dbus.duty_wr   = 1'b0;
    dbus.duty_ch   = '0;
    dbus.duty_data = '0;
    step(3);
    check("reset_out", 32'(out), 32'd0);
    check("reset_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;

`ifndef PWM_CENTER_ALIGN_EN
    // ch0 duty 128 over the reset period of 256
    en_out[0] = 1'b1;
    en_pwm[0] = 1'b1;
    measure(0, 0, 8'd128, 400, clks, hi);
    chk_win("first_wrap", clks, 256, hi[0], 0);
    repeat (2) begin
      measure(-1, 0, 8'd0, 400, clks, hi);
      chk_win("duty128", clks, 256, hi[0], 128);
    end

    // duty 0 and duty above period, period 99 from the next wrap
    period = 8'd99;
    en_out[2:1] = 2'b11;
    en_pwm[2:1] = 2'b11;
    write_duty(1, 8'd0);
    write_duty(2, 8'd200);
    measure(-1, 0, 8'd0, 400, clks, hi);
    measure(-1, 0, 8'd0, 400, clks, hi);
    chk_win("period99", clks, 100, hi[0], 100);
    check("duty0_hi1", 32'(hi[1]), 32'd0);
    check("duty200_hi2", 32'(hi[2]), 32'd100);

    // live enables, one clock of latency
    foreach (vecs[k]) begin
      en_out[vecs[k].ch] = vecs[k].eo;
      en_pwm[vecs[k].ch] = vecs[k].ep;
      step(1);
      check($sformatf("en_vec%0d", k), 32'(out[vecs[k].ch]), 32'(vecs[k].exp));
    end

    // double buffering, including writes next to the load edge
    measure(-1, 0, 8'd0, 400, clks, hi);
    measure(0, 0, 8'd30, 400, clks, hi);
    chk_win("duty_gt_period", clks, 100, hi[0], 100);
    measure(10, 0, 8'd64, 400, clks, hi);
    chk_win("midwrite_old", clks, 100, hi[0], 30);
    measure(0, 0, 8'd80, 400, clks, hi);
    chk_win("midwrite_new", clks, 100, hi[0], 64);
    measure(99, 0, 8'd50, 400, clks, hi);
    chk_win("loadedge_wr_p0", clks, 100, hi[0], 80);
    measure(-1, 0, 8'd0, 400, clks, hi);
    chk_win("loadedge_wr_p1", clks, 100, hi[0], 80);
    measure(0, 0, 8'd99, 400, clks, hi);
    chk_win("loadedge_wr_p2", clks, 100, hi[0], 50);
    measure(-1, 0, 8'd0, 400, clks, hi);
    chk_win("duty_eq_period", clks, 100, hi[0], 99);

    // prescaler is live, period waits for the wrap
    presc  = 4'd3;
    period = 8'd9;
    measure(0, 0, 8'd5, 1000, clks, hi);
    chk_win("presc3_old_period", clks, 400, hi[0], 396);
    measure(-1, 0, 8'd0, 1000, clks, hi);
    chk_win("presc3_period9", clks, 40, hi[0], 20);
`else
    // centre-aligned: period 9, duty 3
    period    = 8'd9;
    en_out[0] = 1'b1;
    en_pwm[0] = 1'b1;
    measure(0, 0, 8'd3, 700, clks, hi);
    chk_win("ca_first_wrap", clks, FIRST_WRAP, hi[0], 0);
    repeat (2) begin
      measure(-1, 0, 8'd0, 100, clks, hi);
      chk_win("ca_period9", clks, 18, hi[0], 5);
    end
`endif

    // asynchronous reset mid-period
    step(7);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_tick", 32'(period_tick), 32'd0);
    presc = 4'd0;
    step(2);
    rst_n = 1'b1;
    measure(-1, 0, 8'd0, 700, clks, hi);
    check("post_rst_wrap", 32'(clks), 32'(FIRST_WRAP));

    // random traffic against the model
    period = 8'($urandom_range(0, 20));
    presc  = 4'($urandom_range(0, 3));
    en_out = 16'($urandom);
    en_pwm = 16'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 7) == 0) begin
        dbus.duty_wr   = 1'b1;
        dbus.duty_ch   = 4'($urandom_range(0, NCH - 1));
        dbus.duty_data = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 24))
                                                     : 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 49) == 0) begin
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        period = 8'($urandom_range(0, 20));
        presc  = 4'($urandom_range(0, 3));
      end
      step(1);
      dbus.duty_wr = 1'b0;
    end
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
Name: pwm_multichannel

Overview:
Parametrised successor to the 16-output PWM peripheral. Drives NUM_CH outputs from one shared prescaled period counter.
- Each channel has its own duty value and an output-enable / PWM-mode enable.
- Duty and period are double-buffered: new values take effect only at a period boundary, so no glitched partial cycles.
- Sits between the SPI register file and the top-level uo_out/uio_out pins.

Parameters:
NUM_CH, 16, number of PWM channels / output bits
CNT_W, 8, width of period counter, period and duty values
PRESC_W, 4, width of clock prescaler divide value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en_out  in  NUM_CH  per-channel output enable; 0 forces the output low
en_pwm  in  NUM_CH  per-channel mode: 1 = PWM, 0 = static high (when en_out=1)
duty_wr  in  1  single-cycle strobe that writes duty_data into the staging register of channel duty_ch
duty_ch  in  $clog2(NUM_CH)  channel index for duty_wr
duty_data  in  CNT_W  duty value (count of high ticks per period)
period  in  CNT_W  terminal count; period length is period+1 ticks
presc  in  PRESC_W  tick = clk divided by presc+1
out  out  NUM_CH  registered PWM outputs
period_tick  out  1  one-clk pulse on the cycle the counter wraps (shadow-load cycle)

Behaviour:
- Reset (async, rst_n=0): presc_cnt=0, cnt=0, all duty staging and shadow registers=0, period_sh = all ones (255 for CNT_W=8), out=0, period_tick=0.
- Prescaler: presc_cnt increments every clk. When presc_cnt==presc it returns to 0 and asserts an internal tick. presc=0 gives a tick every clk.
- Counter, on each tick:
  - If cnt==period_sh: cnt becomes 0, period_tick=1 for that clk, all duty_sh[i] load from staging[i], and period_sh loads from the period input.
  - Otherwise cnt increments.
- A duty_ch value >= NUM_CH is ignored.
- Staging write: on a duty_wr clk, staging[duty_ch] <= duty_data. A write on the same clk as a shadow load is not captured by that load; the shadow register keeps the old staging value and the new value applies at the next wrap.
- Output, registered with 1-clk latency from cnt: out[i] <= en_out[i] & (en_pwm[i] ? (cnt < duty_sh[i]) : 1).
- Boundaries:
  - duty=0: always low.
  - duty > period_sh: always high.
  - duty == period_sh: high for period ticks out of period+1.
  - Changing period or presc mid-period: period takes effect at the next wrap; presc compare is live (no buffering).
  - en_out / en_pwm are live, with the same 1-clk output latency.
- Reset mid-operation returns everything to reset values immediately; the first wrap after release occurs after 256 ticks (period_sh = 255).

Optional Feature:
Macro PWM_CENTER_ALIGN_EN.
- Defined: the counter runs up 0..period_sh, then down to 0 (triangle wave). The direction flips at each end, and each endpoint is held for exactly one tick. period_tick and the shadow load happen when the count reaches 0 while counting down. The output rule is unchanged (cnt < duty), giving a centred pulse of width 2*duty-1 ticks (0 when duty=0) with a period of 2*period_sh ticks.
- Undefined: edge-aligned sawtooth only, as described above. No direction register is synthesised.

Decomposition:
- Shared package pwm_pkg holds: default CNT_W/PRESC_W/NUM_CH constants, the RESET_PERIOD constant (all ones), and the count-direction enum (UP, DOWN) used under PWM_CENTER_ALIGN_EN.
- One natural sub-module: pwm_timebase. It contains the prescaler, the counter, the direction logic and period_sh, and outputs cnt and period_tick.
- The top level instantiates pwm_timebase once and generates NUM_CH compare/staging/shadow slices.

Test Plan:
- presc=0, period=255, ch0 en_out=1 en_pwm=1 duty=128 written before the first wrap -> out[0] high 128 clks then low 128 clks, repeating; period_tick every 256 clks.
- ch1 duty=0, ch2 duty=200 with period=99 -> out[1] constant 0; out[2] constant 1 from the first wrap after the writes.
- en_out[3]=1, en_pwm[3]=0 -> out[3]=1 one clk later; en_out[3]=0 -> out[3]=0 one clk later, regardless of duty.
- Write ch0 duty=64 at cnt=10 -> high time stays at the old value until period_tick, then becomes 64. A write on the period_tick clk takes effect one period later.
- presc=3, period=9, duty=5 -> period_tick every 40 clks; out high 20 clks, low 20.
- Assert rst_n=0 mid-period -> out=0 and period_tick=0 immediately. After release, first period_tick after 256 clks (presc=0).
- Under PWM_CENTER_ALIGN_EN, run with period=9 and duty=3 -> period_tick every 18 ticks; out high for 5 consecutive ticks centred on cnt=0.
